// File: rtl/sfu_out_packer_pkg.sv
// Shared constants and state encoding for the SFU output packer.
// Defaults match the standard 8-column, 16-bit psum array configuration.
package sfu_out_packer_pkg;

  localparam int COL            = 8;
  localparam int PSUM_BW        = 16;
  localparam int OUT_FIFO_DEPTH = 4;
  localparam int OUT_ADDR_BW    = 4;
  localparam int OUT_NUM_ROWS   = 16;

  typedef enum logic {
    GATHER = 1'b0,
    STALL  = 1'b1
  } state_e;

endpackage

// File: rtl/sfu_out_packer_fifo_sync.sv
// Synchronous FIFO: head is the oldest entry, a push lands one edge later; push and pop
// on the same edge are both honoured even when full. The caller never pops when empty.
module fifo_sync #(
  parameter int width = 8,
  parameter int depth = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [width-1:0] push_dat,
  output logic             full,
  output logic             empty,
  output logic [width-1:0] head
);

  localparam int PTR_BW = $clog2(depth);
  localparam logic [PTR_BW:0] DEPTH_CNT = (PTR_BW + 1)'(depth);

  logic [width-1:0]  mem_q [depth];
  logic [PTR_BW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_BW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_BW:0]   count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: it is only observed through head while non-empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_dat;
  end

  assign full  = (count_q == DEPTH_CNT);
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/sfu_out_packer.sv
// Packs per-column SFU results into row words, queues them and writes them to SRAM.
// Last column at edge t -> mem_wen after t+1 (FIFO empty); mem_ready stall holds addr/data; full FIFO -> STALL.
module sfu_out_packer
  import sfu_out_packer_pkg::*;
#(
  parameter int col      = COL,
  parameter int psum_bw  = PSUM_BW,
  parameter int depth    = OUT_FIFO_DEPTH,
  parameter int addr_bw  = OUT_ADDR_BW,
  parameter int num_rows = OUT_NUM_ROWS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [col-1:0]         valid_in,
  input  logic [col*psum_bw-1:0] psum_in,
  input  logic                   mem_ready,
  output logic                   mem_wen,
  output logic [addr_bw-1:0]     mem_addr,
  output logic [col*psum_bw-1:0] mem_data,
  output logic                   done,
  output logic                   busy,
  output logic                   overflow
);

  localparam logic [addr_bw-1:0] LAST_ADDR = addr_bw'(num_rows - 1);

  logic [col-1:0]         mask_q, mask_d;
  logic [col*psum_bw-1:0] hold_q, hold_d;
  state_e                 state_q, state_d;
  logic [addr_bw-1:0]     addr_q, addr_d;
  logic                   done_q, done_d;
  logic                   overflow_q, overflow_d;

  logic                   fifo_full, fifo_empty, push, xfer, fifo_space, row_full;
  logic [col*psum_bw-1:0] fifo_head;

  assign xfer       = !fifo_empty && mem_ready;
  assign fifo_space = !fifo_full || xfer;
  assign row_full   = &mask_q;

  always_comb begin
    mask_d     = mask_q;
    hold_d     = hold_q;
    state_d    = state_q;
    addr_d     = addr_q;
    done_d     = 1'b0;
    overflow_d = overflow_q;
    push       = 1'b0;

    if (xfer) begin
      addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
      done_d = (addr_q == LAST_ADDR);
    end

    if (start) begin
      mask_d     = '0;
      state_d    = GATHER;
      addr_d     = '0;
      done_d     = 1'b0;
      overflow_d = 1'b0;
    end else if (state_q == STALL) begin
      if (|valid_in) overflow_d = 1'b1;
      if (fifo_space) begin
        push    = 1'b1;
        mask_d  = '0;
        state_d = GATHER;
      end
    end else begin
      if (row_full) begin
        if (fifo_space) begin
          push   = 1'b1;
          mask_d = '0;
        end else begin
          state_d = STALL;
        end
      end
      // mask_d already reflects a push-clear, so same-edge arrivals land in fresh slots.
      for (int c = 0; c < col; c++) begin
        if (valid_in[c]) begin
          if (!mask_d[c]) begin
            hold_d[c*psum_bw +: psum_bw] = psum_in[c*psum_bw +: psum_bw];
            mask_d[c] = 1'b1;
          end else begin
            overflow_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q     <= '0;
      hold_q     <= '0;
      state_q    <= GATHER;
      addr_q     <= '0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      mask_q     <= mask_d;
      hold_q     <= hold_d;
      state_q    <= state_d;
      addr_q     <= addr_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
    end
  end

  fifo_sync #(
    .width (col*psum_bw),
    .depth (depth)
  ) u_row_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (xfer),
    .push_dat (hold_q),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (fifo_head)
  );

  assign mem_wen  = !fifo_empty;
  assign mem_addr = addr_q;
  assign mem_data = fifo_empty ? '0 : fifo_head;
  assign done     = done_q;
  assign overflow = overflow_q;
  assign busy     = (|mask_q) || (state_q == STALL) || !fifo_empty;

endmodule

// File: tb/tb_sfu_out_packer.sv
// Directed bench for sfu_out_packer: vector table for aligned/skewed rows, then
// hand sequences for duplicates, backpressure/STALL, wrap/done and async reset.
module tb_sfu_out_packer;
  import sfu_out_packer_pkg::*;

  localparam int W = COL * PSUM_BW;

  logic                   clk = 1'b0;
  logic                   reset, start, mem_ready;
  logic [COL-1:0]         valid_in;
  logic [W-1:0]           psum_in;
  logic                   mem_wen, done, busy, overflow;
  logic [OUT_ADDR_BW-1:0] mem_addr;
  logic [W-1:0]           mem_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [COL-1:0]         vin;
    logic [W-1:0]           psum;
    logic                   exp_wen;
    logic [OUT_ADDR_BW-1:0] exp_addr;
    logic [W-1:0]           exp_data;
    logic                   exp_busy;
    logic                   exp_ovf;
  } vec_t;

  vec_t tv [9];

  always #5 clk = ~clk;

  sfu_out_packer #(
    .col      (COL),
    .psum_bw  (PSUM_BW),
    .depth    (OUT_FIFO_DEPTH),
    .addr_bw  (OUT_ADDR_BW),
    .num_rows (OUT_NUM_ROWS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .valid_in  (valid_in),
    .psum_in   (psum_in),
    .mem_ready (mem_ready),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .done      (done),
    .busy      (busy),
    .overflow  (overflow)
  );

  // Column c = base + c where sel[c] is set, otherwise the junk value.
  function automatic logic [W-1:0] mk(input logic [15:0] base, input logic [COL-1:0] sel,
                                      input logic [15:0] junk);
    logic [W-1:0] r;
    r = '0;
    for (int c = 0; c < COL; c++) r[c*PSUM_BW +: PSUM_BW] = sel[c] ? base + 16'(c) : junk;
    return r;
  endfunction

  function automatic logic [W-1:0] fill(input logic [15:0] v);
    return mk(16'h0, '0, v);
  endfunction

  function automatic vec_t mkv(input logic [COL-1:0] vin, input logic [W-1:0] psum,
                               input logic wen, input logic [OUT_ADDR_BW-1:0] addr,
                               input logic [W-1:0] data, input logic bsy, input logic ovf);
    vec_t v;
    v.vin = vin; v.psum = psum; v.exp_wen = wen; v.exp_addr = addr;
    v.exp_data = data; v.exp_busy = bsy; v.exp_ovf = ovf;
    return v;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_wen;
    logic [W-1:0] exp_row;

    // Aligned arrival, then skewed arrival (cols 0-3 at cycle 3, cols 4-7 at cycle 6).
    tv[0] = mkv(8'hFF, mk(16'h1, 8'hFF, 16'h0),    1'b0, 4'd0, '0,                         1'b1, 1'b0);
    tv[1] = mkv(8'h00, '0,                         1'b1, 4'd0, mk(16'h1, 8'hFF, 16'h0),    1'b1, 1'b0);
    tv[2] = mkv(8'h00, '0,                         1'b0, 4'd1, '0,                         1'b0, 1'b0);
    tv[3] = mkv(8'h0F, mk(16'h10, 8'h0F, 16'hEE),  1'b0, 4'd1, '0,                         1'b1, 1'b0);
    tv[4] = mkv(8'h00, '0,                         1'b0, 4'd1, '0,                         1'b1, 1'b0);
    tv[5] = mkv(8'h00, '0,                         1'b0, 4'd1, '0,                         1'b1, 1'b0);
    tv[6] = mkv(8'hF0, mk(16'h10, 8'hF0, 16'hDD),  1'b0, 4'd1, '0,                         1'b1, 1'b0);
    tv[7] = mkv(8'h00, '0,                         1'b1, 4'd1, mk(16'h10, 8'hFF, 16'h0),   1'b1, 1'b0);
    tv[8] = mkv(8'h00, '0,                         1'b0, 4'd2, '0,                         1'b0, 1'b0);

    reset = 1'b1; start = 1'b0; valid_in = '0; psum_in = '0; mem_ready = 1'b1;
    #12;
    chk("rst_wen", mem_wen, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_data", mem_data, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      valid_in = tv[i].vin;
      psum_in  = tv[i].psum;
      step();
      chk($sformatf("vec%0d_wen", i), mem_wen, tv[i].exp_wen);
      chk($sformatf("vec%0d_addr", i), mem_addr, tv[i].exp_addr);
      chk($sformatf("vec%0d_data", i), mem_data, tv[i].exp_data);
      chk($sformatf("vec%0d_busy", i), busy, tv[i].exp_busy);
      chk($sformatf("vec%0d_ovf", i), overflow, tv[i].exp_ovf);
    end
    valid_in = '0;

    // Duplicate column 2: first value kept, second dropped with overflow.
    valid_in = 8'h04; psum_in = fill(16'hAA);
    step();
    chk("dup_first_ovf", overflow, 0);
    psum_in = fill(16'hBB);
    step();
    chk("dup_second_ovf", overflow, 1);
    valid_in = 8'hFB; psum_in = mk(16'h30, 8'hFB, 16'hCC);
    step();
    chk("dup_nowen", mem_wen, 0);
    valid_in = '0;
    step();
    chk("dup_wen", mem_wen, 1);
    chk("dup_addr", mem_addr, 2);
    chk("dup_data", mem_data, mk(16'h30, 8'hFB, 16'hAA));
    step();
    chk("dup_drained", mem_wen, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start1_ovf", overflow, 0);
    chk("start1_addr", mem_addr, 0);
    chk("start1_busy", busy, 0);

    // Backpressure: five rows against a blocked SRAM; fifth row stalls.
    mem_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      valid_in = 8'hFF; psum_in = fill(16'(k));
      step();
      if (k >= 2) begin
        chk($sformatf("bp_hold%0d_addr", k), mem_addr, 0);
        chk($sformatf("bp_hold%0d_data", k), mem_data, fill(16'h1));
      end
    end
    valid_in = '0;
    step();
    chk("bp_stall_busy", busy, 1);
    chk("bp_stall_wen", mem_wen, 1);
    valid_in = 8'h01; psum_in = fill(16'h99);
    step();
    valid_in = '0;
    chk("bp_stall_ovf", overflow, 1);
    chk("bp_stall_data", mem_data, fill(16'h1));
    mem_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_wr%0d_wen", k), mem_wen, 1);
      chk($sformatf("bp_wr%0d_addr", k), mem_addr, k);
      chk($sformatf("bp_wr%0d_data", k), mem_data, fill(16'(k + 1)));
      step();
    end
    chk("bp_end_wen", mem_wen, 0);
    chk("bp_end_busy", busy, 0);
    chk("bp_ovf_sticky", overflow, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start2_ovf", overflow, 0);
    chk("start2_addr", mem_addr, 0);

    // Wrap: 17 back-to-back rows; row w written at addr w mod 16, done after addr 15.
    for (int cyc = 0; cyc < 24; cyc++) begin
      if (cyc < 17) begin
        valid_in = 8'hFF; psum_in = mk(16'(cyc * 256), 8'hFF, 16'h0);
      end else begin
        valid_in = '0;
      end
      exp_wen = (cyc >= 2) && (cyc < 19);
      exp_row = exp_wen ? mk(16'((cyc - 2) * 256), 8'hFF, 16'h0) : '0;
      chk($sformatf("wrap%0d_wen", cyc), mem_wen, exp_wen);
      if (exp_wen) chk($sformatf("wrap%0d_addr", cyc), mem_addr, (cyc - 2) % 16);
      chk($sformatf("wrap%0d_data", cyc), mem_data, exp_row);
      step();
      chk($sformatf("wrap%0d_done", cyc), done, (cyc == 17));
    end

    // Async reset in the middle of a partial gather.
    valid_in = 8'h0F; psum_in = mk(16'h50, 8'h0F, 16'hEE);
    step();
    valid_in = '0;
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_addr", mem_addr, 1);
    #1 reset = 1'b1;
    #1;
    chk("arst_wen", mem_wen, 0);
    chk("arst_addr", mem_addr, 0);
    chk("arst_busy", busy, 0);
    chk("arst_data", mem_data, 0);
    #2 reset = 1'b0;
    valid_in = 8'hF0; psum_in = mk(16'h50, 8'hF0, 16'hDD);
    step();
    valid_in = '0;
    step();
    chk("post_rst_partial_wen", mem_wen, 0);
    chk("post_rst_partial_busy", busy, 1);
    valid_in = 8'h0F; psum_in = mk(16'h50, 8'h0F, 16'hEE);
    step();
    valid_in = '0;
    step();
    chk("post_rst_wen", mem_wen, 1);
    chk("post_rst_addr", mem_addr, 0);
    chk("post_rst_data", mem_data, mk(16'h50, 8'hFF, 16'h0));
    step();
    chk("post_rst_drained", mem_wen, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
